pe_set_load_ctrl: RTL and testbench

Sequencer that loads ifmap data into the PE array one PE set at a time. It accepts a stream of ifmap words from the ifmap source through a valid/ready handshake and steers exactly P*Q accepted words into each PE set. It then advances to the next set and signals completion after the configured number of sets. It sits inside pe_array_control, between the ifmap buffer and the per-set ifmap write ports.

---
 rtl/pe_set_load_ctrl_pkg.sv | 23 ++
 rtl/pe_set_load_ctrl_if.sv | 31 +++
 rtl/pe_set_load_ctrl_elem_counter.sv | 28 ++
 rtl/pe_set_load_ctrl.sv | 86 ++++++++
 tb/tb_pe_set_load_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pe_set_load_ctrl_pkg.sv
// Shared types and constants for the PE-set ifmap load sequencer.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_P        = 3;
  localparam int DEF_Q        = 3;
  localparam int DEF_NUM_SETS = 4;

  // A zero or out-of-range request means "load every set".
  function automatic int clamp_limit(input int cfg, input int num_sets);
    if (cfg == 0 || cfg > num_sets) begin
      return num_sets;
    end else begin
      return cfg;
    end
  endfunction

endpackage

// File: rtl/pe_set_load_ctrl_if.sv
// Control, source handshake and PE write-strobe bundle of the load sequencer.
interface pe_set_load_ctrl_if
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int P        = DEF_P,
  parameter int Q        = DEF_Q,
  parameter int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  parameter int ELEM_W   = (P * Q > 1) ? $clog2(P * Q) : 1
);
  logic                start;
  logic                abort;
  logic [SET_W:0]      num_sets_cfg;
  logic                src_valid;
  logic                src_ready;
  logic [SET_W-1:0]    pe_set_sel;
  logic [ELEM_W-1:0]   elem_idx;
  logic [NUM_SETS-1:0] pe_wr_en;
  logic                busy;
  logic                done;

  modport master (
    output start, abort, num_sets_cfg, src_valid,
    input  src_ready, pe_set_sel, elem_idx, pe_wr_en, busy, done
  );

  modport slave (
    input  start, abort, num_sets_cfg, src_valid,
    output src_ready, pe_set_sel, elem_idx, pe_wr_en, busy, done
  );
endinterface

// File: rtl/pe_set_load_ctrl_elem_counter.sv
// Modulo-(P*Q) element counter; wrap marks the last word of a set being written.
module pe_elem_counter #(
  parameter int P      = 3,
  parameter int Q      = 3,
  parameter int ELEM_W = (P * Q > 1) ? $clog2(P * Q) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clr,
  output logic [ELEM_W-1:0] count,
  output logic              wrap
);
  localparam int LAST = P * Q - 1;

  assign wrap = en && (count == ELEM_W'(LAST));

  // Element position register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr || wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/pe_set_load_ctrl.sv
// Steers P*Q accepted ifmap words into each PE set in turn, then pulses done.
module pe_set_load_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int P        = DEF_P,
  parameter int Q        = DEF_Q,
  parameter int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  parameter int ELEM_W   = (P * Q > 1) ? $clog2(P * Q) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  pe_set_load_ctrl_if.slave  bus
);
  state_t           state;
  logic [SET_W-1:0] set_sel;
  logic [SET_W:0]   limit;
  logic             beat;
  logic             elem_wrap;
  logic             elem_clr;
  logic             last_set;

  // abort blocks the handshake so a coincident word is never written.
  assign bus.src_ready  = (state == LOAD) && !bus.abort;
  assign beat           = bus.src_valid && bus.src_ready;
  assign elem_clr       = bus.abort || (state != LOAD);
  assign last_set       = ({1'b0, set_sel} == (limit - 1'b1));

  assign bus.pe_set_sel = set_sel;
  assign bus.pe_wr_en   = beat ? (NUM_SETS'(1'b1) << set_sel) : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

  pe_elem_counter #(
    .P      (P),
    .Q      (Q),
    .ELEM_W (ELEM_W)
  ) u_elem_counter (
    .clk   (clk),
    .rstn  (rstn),
    .en    (beat),
    .clr   (elem_clr),
    .count (bus.elem_idx),
    .wrap  (elem_wrap)
  );

  // Pass FSM with set counter and latched set limit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      set_sel <= '0;
      limit   <= (SET_W+1)'(NUM_SETS);
    end else begin
      case (state)
        IDLE: begin
          set_sel <= '0;
          if (bus.start && !bus.abort) begin
            limit <= (SET_W+1)'(clamp_limit(int'(bus.num_sets_cfg), NUM_SETS));
            state <= LOAD;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            set_sel <= '0;
            state   <= IDLE;
          end else if (elem_wrap) begin
            if (last_set) begin
              set_sel <= '0;
              state   <= DONE;
            end else begin
              set_sel <= set_sel + 1'b1;
            end
          end
        end
        DONE: begin
          set_sel <= '0;
          state   <= IDLE;
        end
        default: begin
          set_sel <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pe_set_load_ctrl.sv
// Scoreboard bench for pe_set_load_ctrl: expected (set, elem) writes are queued per pass.
module tb_pe_set_load_ctrl;
  localparam int PQ = 9;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   q_set[$];
  int   q_elem[$];

  pe_set_load_ctrl_if bus ();

  pe_set_load_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_sets_cfg = 3'd4; bus.src_valid = 1'b1;
    #3;
    total++;
    if ({bus.src_ready, bus.pe_set_sel, bus.elem_idx, bus.pe_wr_en, bus.busy, bus.done} !== 13'd0) begin
      $display("FAIL reset_outputs got=%b want=0",
               {bus.src_ready, bus.pe_set_sel, bus.elem_idx, bus.pe_wr_en, bus.busy, bus.done});
    end else passed++;
    #4 rstn = 1'b1;
    bus.src_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one full pass; toggle alternates src_valid, poke holds start high and changes cfg mid-pass.
  task automatic run_pass(input int cfg, input int exp_lim, input bit toggle, input bit poke);
    int  last_c;
    bit  got_done;
    q_set.delete(); q_elem.delete();
    for (int s = 0; s < exp_lim; s++)
      for (int e = 0; e < PQ; e++) begin
        q_set.push_back(s); q_elem.push_back(e);
      end
    bus.start = 1'b1; bus.num_sets_cfg = 3'(cfg); bus.src_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = poke;
    if (poke) bus.num_sets_cfg = 3'd4;
    last_c = -1; got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      bus.src_valid = toggle ? (c % 2 == 0) : 1'b1;
      #4;
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        total++;
        if (q_set.size() != 0) $display("FAIL done_early remaining=%0d want=0", q_set.size());
        else passed++;
        total++;
        if (c !== last_c + 1) $display("FAIL done_cycle got=%0d want=%0d", c, last_c + 1);
        else passed++;
        if (!toggle) begin
          total++;
          if (c !== exp_lim * PQ) $display("FAIL done_abs_cycle got=%0d want=%0d", c, exp_lim * PQ);
          else passed++;
        end
      end else begin
        total++;
        if (bus.busy !== 1'b1 || bus.src_ready !== 1'b1) $display("FAIL load_busy busy=%b ready=%b want=1/1", bus.busy, bus.src_ready);
        else passed++;
        if (bus.src_valid) begin
          total++;
          if (q_set.size() == 0) begin
            $display("FAIL extra_write wr_en=%b want=none", bus.pe_wr_en);
          end else if (bus.pe_wr_en !== 4'(1 << q_set[0]) || int'(bus.pe_set_sel) !== q_set[0] ||
                       int'(bus.elem_idx) !== q_elem[0]) begin
            $display("FAIL beat_write wr_en=%b sel=%0d elem=%0d want wr_en=%b sel=%0d elem=%0d",
                     bus.pe_wr_en, bus.pe_set_sel, bus.elem_idx, 4'(1 << q_set[0]), q_set[0], q_elem[0]);
          end else passed++;
          if (q_set.size() != 0) begin
            void'(q_set.pop_front()); void'(q_elem.pop_front());
          end
          last_c = c;
        end else begin
          total++;
          if (bus.pe_wr_en !== 4'd0 || (q_set.size() != 0 &&
              (int'(bus.elem_idx) !== q_elem[0] || int'(bus.pe_set_sel) !== q_set[0])))
            $display("FAIL stall_hold wr_en=%b elem=%0d sel=%0d want wr_en=0 elem=%0d",
                     bus.pe_wr_en, bus.elem_idx, bus.pe_set_sel, q_elem.size() ? q_elem[0] : 0);
          else passed++;
        end
      end
      @(posedge clk); #1;
    end
    if (!got_done) begin
      total++;
      $display("FAIL done_timeout got=none want=pulse");
    end
    bus.start = 1'b0; bus.src_valid = 1'b0;
    #4;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.src_ready !== 1'b0)
      $display("FAIL after_done busy=%b done=%b ready=%b want=0/0/0", bus.busy, bus.done, bus.src_ready);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    bus.start = 1'b1; bus.num_sets_cfg = 3'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      bus.src_valid = 1'b1;
      bus.abort = (c == 12);
      #4;
      total++;
      if (c < 12) begin
        if (bus.pe_wr_en !== 4'(1 << (c / PQ))) $display("FAIL abort_pre_write got=%b want=%b", bus.pe_wr_en, 4'(1 << (c / PQ)));
        else passed++;
      end else begin
        if (bus.pe_wr_en !== 4'd0 || bus.src_ready !== 1'b0 || bus.elem_idx !== 4'd3)
          $display("FAIL abort_cycle wr_en=%b ready=%b elem=%0d want 0/0/3", bus.pe_wr_en, bus.src_ready, bus.elem_idx);
        else passed++;
      end
      @(posedge clk); #1;
    end
    bus.abort = 1'b0; bus.src_valid = 1'b0;
    #4;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.elem_idx !== 4'd0 || bus.pe_set_sel !== 2'd0)
      $display("FAIL abort_idle busy=%b done=%b elem=%0d sel=%0d want 0", bus.busy, bus.done, bus.elem_idx, bus.pe_set_sel);
    else passed++;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    #4;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL abort_wins_start busy=%b want=0", bus.busy);
    else passed++;
    @(posedge clk); #1;
    run_pass(1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1; bus.num_sets_cfg = 3'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      bus.src_valid = 1'b1;
      #4;
      if (c == 20) begin
        total++;
        if (bus.pe_wr_en !== 4'b0100) $display("FAIL pre_reset_write got=%b want=0100", bus.pe_wr_en);
        else passed++;
        #1 rstn = 1'b0;
        #1;
        total++;
        if ({bus.src_ready, bus.pe_set_sel, bus.elem_idx, bus.pe_wr_en, bus.busy, bus.done} !== 13'd0)
          $display("FAIL midpass_reset got=%b want=0",
                   {bus.src_ready, bus.pe_set_sel, bus.elem_idx, bus.pe_wr_en, bus.busy, bus.done});
        else passed++;
        #1 rstn = 1'b1;
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 4; c++) begin
      bus.src_valid = 1'b1;
      #4;
      total++;
      if (bus.busy !== 1'b0 || bus.src_ready !== 1'b0 || bus.pe_wr_en !== 4'd0)
        $display("FAIL post_reset_idle busy=%b ready=%b wr_en=%b want 0", bus.busy, bus.src_ready, bus.pe_wr_en);
      else passed++;
      @(posedge clk); #1;
    end
    bus.src_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    run_pass(4, 4, 1'b0, 1'b0);   // full array, continuous source
    run_pass(2, 2, 1'b1, 1'b0);   // two sets, source stalls every other cycle
    run_pass(0, 4, 1'b0, 1'b0);   // zero clamps to all sets
    run_pass(7, 4, 1'b0, 1'b0);   // oversize clamps to all sets
    test_abort();
    test_async_reset();
    run_pass(2, 2, 1'b0, 1'b1);   // start held through LOAD/DONE is ignored
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
